// File: rtl/logic_reduce_acc.sv
// ---------------------------------------------------------------------------
// logic_reduce_acc
//
// Purpose:
//   Streaming reduction stage. Accepts a burst of WIDTH-bit words over a
//   valid/ready handshake, delimited by IN_LAST, and folds the burst into a
//   single word using the operator chosen on the first beat (AND, OR, XOR or
//   NAND). The result, the number of beats in the burst and an overflow flag
//   are presented on a second valid/ready handshake.
//
// Parameters:
//   WIDTH  data width of input and result words
//   CNT_W  width of the beat counter; the counter saturates at 2^CNT_W-1
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        asynchronous, active-high reset
//   IN_VALID   input word valid
//   IN_READY   block can accept an input word (combinational)
//   IN_DATA    input word
//   IN_LAST    final word of the current burst
//   MODE       operator 00 AND, 01 OR, 10 XOR, 11 NAND (first beat only)
//   OUT_VALID  result valid
//   OUT_READY  downstream accepts the result
//   OUT_DATA   reduced result
//   OUT_COUNT  number of beats in the burst (saturating)
//   OUT_OVF    burst was longer than 2^CNT_W-1 beats
// ---------------------------------------------------------------------------
module logic_reduce_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_LAST,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [CNT_W-1:0] OUT_COUNT,
  output logic             OUT_OVF
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [1:0]       mode_q,      mode_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             ovf_q,       ovf_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q,   out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             beat_acc;

  // NAND accumulates as AND; the inversion is applied once when the result
  // is loaded, otherwise a multi-beat NAND would alternate polarity.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [1:0]       mode,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (mode)
      MODE_OR:  r = a | b;
      MODE_XOR: r = a ^ b;
      default:  r = a & b;
    endcase
    return r;
  endfunction

  // Ready depends on RST directly so it drops the moment reset asserts,
  // without waiting for the state register to be cleared.
  assign IN_READY = (state_q != S_DONE) && !RST;
  assign beat_acc = IN_VALID && IN_READY;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (beat_acc) begin
          acc_d   = IN_DATA;
          mode_d  = MODE;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
          state_d = IN_LAST ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (beat_acc) begin
          acc_d = apply_op(mode_q, acc_q, IN_DATA);
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            ovf_d = 1'b1;
          end
          if (IN_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_valid_q && OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The result registers load from the post-beat accumulator values so the
    // output is visible in the cycle right after the last beat is accepted.
    if (beat_acc && IN_LAST) begin
      out_data_d  = (mode_d == MODE_NAND) ? ~acc_d : acc_d;
      out_count_d = cnt_d;
      out_ovf_d   = ovf_d;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mode_q      <= MODE_AND;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_COUNT = out_count_q;
  assign OUT_OVF   = out_ovf_q;

endmodule

// File: tb/tb_logic_reduce_acc.sv
// ---------------------------------------------------------------------------
// tb_logic_reduce_acc
//
// Self-checking bench for logic_reduce_acc (WIDTH=8, CNT_W=4). Inputs are
// driven and outputs sampled on the falling edge of CLK.
// ---------------------------------------------------------------------------
module tb_logic_reduce_acc;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] IN_DATA;
  logic       IN_LAST;
  logic [1:0] MODE;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] OUT_DATA;
  logic [3:0] OUT_COUNT;
  logic       OUT_OVF;

  int passCount  = 0;
  int checkCount = 0;

  logic_reduce_acc #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_LAST   (IN_LAST),
    .MODE      (MODE),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_COUNT (OUT_COUNT),
    .OUT_OVF   (OUT_OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]      modeFirst;
    logic [1:0]      modeRest;
    logic [2:0]      n;
    logic [3:0][7:0] data;
    logic [1:0]      gap;
    logic            earlyReady;
    logic [7:0]      expData;
    logic [3:0]      expCount;
    logic            expOvf;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mkVec(input logic [1:0] mf, input logic [1:0] mr,
                                 input logic [2:0] n, input logic [7:0] d0,
                                 input logic [7:0] d1, input logic [7:0] d2,
                                 input logic [7:0] d3, input logic [1:0] gap,
                                 input logic er, input logic [7:0] ed,
                                 input logic [3:0] ec, input logic eo);
    vec_t v;
    v.modeFirst  = mf;
    v.modeRest   = mr;
    v.n          = n;
    v.data[0]    = d0;
    v.data[1]    = d1;
    v.data[2]    = d2;
    v.data[3]    = d3;
    v.gap        = gap;
    v.earlyReady = er;
    v.expData    = ed;
    v.expCount   = ec;
    v.expOvf     = eo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Presents one beat (called on a falling edge), waits for acceptance and
  // returns on the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic [7:0] d, input logic last,
                               input logic [1:0] m, input int gap);
    int waited;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_LAST  = last;
    MODE     = m;
    waited   = 0;
    while (!IN_READY && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (!IN_READY) checkOutput("in_ready_timeout", {31'd0, IN_READY}, 32'd1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_DATA  = 'x;
    IN_LAST  = 'x;
    repeat (gap) @(negedge CLK);
  endtask

  // Checks the result right after the last beat, optionally holds
  // backpressure for a few cycles, then completes the result handshake.
  task automatic expectResult(input string name, input logic [7:0] ed,
                              input logic [3:0] ec, input logic eo,
                              input int holdCycles);
    checkOutput({name, "_valid"}, {31'd0, OUT_VALID}, 32'd1);
    checkOutput({name, "_data"},  {24'd0, OUT_DATA},  {24'd0, ed});
    checkOutput({name, "_count"}, {28'd0, OUT_COUNT}, {28'd0, ec});
    checkOutput({name, "_ovf"},   {31'd0, OUT_OVF},   {31'd0, eo});
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge CLK);
      checkOutput({name, "_hold_valid"}, {31'd0, OUT_VALID}, 32'd1);
      checkOutput({name, "_hold_data"},  {24'd0, OUT_DATA},  {24'd0, ed});
      checkOutput({name, "_hold_inrdy"}, {31'd0, IN_READY},  32'd0);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    checkOutput({name, "_valid_drop"}, {31'd0, OUT_VALID}, 32'd0);
    checkOutput({name, "_inrdy_back"}, {31'd0, IN_READY},  32'd1);
    checkOutput({name, "_data_kept"},  {24'd0, OUT_DATA},  {24'd0, ed});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    logic [1:0] m;
    logic [7:0] expD;
    int         n;

    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    IN_LAST   = 1'b0;
    MODE      = 2'b00;
    OUT_READY = 1'b0;

    vecs[0] = mkVec(2'b00, 2'b00, 3'd3, 8'hF0, 8'h3C, 8'hFF, 8'h00, 2'd0, 1'b0, 8'h30, 4'd3, 1'b0);
    vecs[1] = mkVec(2'b10, 2'b01, 3'd3, 8'h0F, 8'hF0, 8'hAA, 8'h00, 2'd2, 1'b1, 8'h55, 4'd3, 1'b0);
    vecs[2] = mkVec(2'b11, 2'b11, 3'd1, 8'hA5, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'h5A, 4'd1, 1'b0);
    vecs[3] = mkVec(2'b11, 2'b00, 3'd2, 8'hFF, 8'h0F, 8'h00, 8'h00, 2'd1, 1'b1, 8'hF0, 4'd2, 1'b0);
    vecs[4] = mkVec(2'b01, 2'b00, 3'd4, 8'h10, 8'h01, 8'h40, 8'h02, 2'd0, 1'b0, 8'h53, 4'd4, 1'b0);

    repeat (2) @(negedge CLK);
    checkOutput("reset_inrdy", {31'd0, IN_READY},  32'd0);
    checkOutput("reset_valid", {31'd0, OUT_VALID}, 32'd0);
    checkOutput("reset_data",  {24'd0, OUT_DATA},  32'd0);
    checkOutput("reset_count", {28'd0, OUT_COUNT}, 32'd0);
    checkOutput("reset_ovf",   {31'd0, OUT_OVF},   32'd0);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("idle_inrdy", {31'd0, IN_READY}, 32'd1);

    for (int v = 0; v < 5; v++) begin
      OUT_READY = vecs[v].earlyReady;
      for (int b = 0; b < int'(vecs[v].n); b++) begin
        applyStimulus(vecs[v].data[b], (b == int'(vecs[v].n) - 1),
                      (b == 0) ? vecs[v].modeFirst : vecs[v].modeRest,
                      (b == int'(vecs[v].n) - 1) ? 0 : int'(vecs[v].gap));
        if (b != int'(vecs[v].n) - 1)
          checkOutput($sformatf("vec%0d_no_early_valid", v), {31'd0, OUT_VALID}, 32'd0);
      end
      expectResult($sformatf("vec%0d", v), vecs[v].expData, vecs[v].expCount,
                   vecs[v].expOvf, 0);
    end

    // Backpressure; a word offered during DONE must wait for IN_READY.
    applyStimulus(8'h01, 1'b0, 2'b01, 0);
    applyStimulus(8'h02, 1'b1, 2'b01, 0);
    IN_VALID = 1'b1;
    IN_DATA  = 8'h77;
    IN_LAST  = 1'b1;
    MODE     = 2'b01;
    expectResult("bp", 8'h03, 4'd2, 1'b0, 5);
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_DATA  = 'x;
    IN_LAST  = 'x;
    expectResult("bp_next", 8'h77, 4'd1, 1'b0, 0);

    // Counter saturation and overflow, then a short burst clears the flag.
    for (int b = 0; b < 16; b++) applyStimulus(8'h01, 1'b0, 2'b01, 0);
    applyStimulus(8'h80, 1'b1, 2'b01, 0);
    expectResult("ovf", 8'h81, 4'd15, 1'b1, 0);
    applyStimulus(8'h04, 1'b0, 2'b01, 0);
    applyStimulus(8'h08, 1'b1, 2'b01, 0);
    expectResult("post_ovf", 8'h0C, 4'd2, 1'b0, 0);

    // Asynchronous reset in the middle of a burst.
    applyStimulus(8'hF0, 1'b0, 2'b00, 0);
    applyStimulus(8'hF3, 1'b0, 2'b00, 0);
    IN_VALID = 1'b1;
    IN_DATA  = 8'h11;
    IN_LAST  = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rst_mid_inrdy", {31'd0, IN_READY},  32'd0);
    checkOutput("rst_mid_valid", {31'd0, OUT_VALID}, 32'd0);
    checkOutput("rst_mid_data",  {24'd0, OUT_DATA},  32'd0);
    checkOutput("rst_mid_count", {28'd0, OUT_COUNT}, 32'd0);
    checkOutput("rst_mid_ovf",   {31'd0, OUT_OVF},   32'd0);
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    applyStimulus(8'hFF, 1'b0, 2'b00, 0);
    applyStimulus(8'h0F, 1'b1, 2'b00, 0);
    expectResult("after_rst", 8'h0F, 4'd2, 1'b0, 0);

    // Random bursts against a reduction model.
    for (int r = 0; r < 30; r++) begin
      q.delete();
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 19) : $urandom_range(1, 6);
      m = 2'($urandom_range(0, 3));
      for (int b = 0; b < n; b++) q.push_back(8'($urandom));
      for (int b = 0; b < n; b++)
        applyStimulus(q[b], (b == n - 1), (b == 0) ? m : 2'($urandom_range(0, 3)),
                      (b == n - 1) ? 0 : $urandom_range(0, 2));
      case (m)
        2'b01:   expD = q.or();
        2'b10:   expD = q.xor();
        2'b11:   expD = ~q.and();
        default: expD = q.and();
      endcase
      expectResult($sformatf("rand%0d", r), expD, (n > 15) ? 4'd15 : 4'(n),
                   (n > 15), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
